// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the tone waveform generator: prescale word width,
// clock and phase-resolution constants, the generator state enum and the
// prescale clamp helper used at capture time.
// Tone frequency = CLK_HZ / STEPS_PER_PERIOD / prescale.
// -----------------------------------------------------------------------------
package tone_pkg;

  localparam int PRESCALE_W       = 10;
  localparam int CLK_HZ           = 31_500_000;
  localparam int STEPS_PER_PERIOD = 256;
  localparam int PHASE_W          = $clog2(STEPS_PER_PERIOD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tone_state_e;

  // Raise too-small prescale words to the minimum supported divide ratio.
  function automatic logic [PRESCALE_W-1:0] clamp_prescale(
    input logic [PRESCALE_W-1:0] ps,
    input logic [PRESCALE_W-1:0] min_ps
  );
    return (ps < min_ps) ? min_ps : ps;
  endfunction

endpackage

// File: rtl/tone_step_divider.sv
// -----------------------------------------------------------------------------
// tone_step_divider
// Clock divider producing one phase-step pulse every `prescale` cycles.
// Ports:
//   clk, resetN   system clock, synchronous active-low reset
//   clear         holds the counter at 0 and suppresses step_tick
//   prescale      divide ratio (terminal count is prescale-1)
//   step_tick     high for the one cycle in which div_cnt == prescale-1
// -----------------------------------------------------------------------------
module tone_step_divider
  import tone_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step_tick
);

  logic [PRESCALE_W-1:0] div_cnt_q, div_cnt_d;
  logic [PRESCALE_W-1:0] last_cnt;

  assign last_cnt  = prescale - PRESCALE_W'(1);
  assign step_tick = !clear && (div_cnt_q == last_cnt);

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q + PRESCALE_W'(1);
    if (clear || step_tick) begin
      div_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/tone_wave_generator.sv
// -----------------------------------------------------------------------------
// tone_wave_generator
// Consumer side of the tone prescale interface. Divides the 31.5 MHz clock by
// the active prescale word into 256 phase steps per tone period and produces a
// square wave plus a signed sample word for the audio codec path. Note changes
// requested mid-tone are parked and applied only at the 255->0 phase wrap.
//
// Ports:
//   clk, resetN    system clock, synchronous active-low reset
//   enable         sound on (1) / off (0); off drains to the end of the period
//   pre_scale_in   prescale word from the tone decoder
//   load_req       pre_scale_in valid, held by the requester until load_ack
//   load_ack       one-cycle pulse when a word becomes the active prescale
//   step_tick      one-cycle pulse per phase step
//   phase          current phase within the tone period
//   square_out     phase[7] while running, 0 in IDLE
//   sample_out     signed sample, aligned with phase, 0 in IDLE
//   busy           high in RUN and DRAIN
//
// Build option: define TONE_TRIANGLE_EN to shape sample_out as a triangle
// wave; otherwise it is a +/-AMPLITUDE square.
// -----------------------------------------------------------------------------
module tone_wave_generator
  import tone_pkg::*;
#(
  parameter logic [PRESCALE_W-1:0] MIN_PRESCALE = 10'd8,
  parameter logic signed [15:0]    AMPLITUDE    = 16'sd8192
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] pre_scale_in,
  input  logic                  load_req,
  output logic                  load_ack,
  output logic                  step_tick,
  output logic [PHASE_W-1:0]    phase,
  output logic                  square_out,
  output logic signed [15:0]    sample_out,
  output logic                  busy
);

  tone_state_e             state_q, state_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [PRESCALE_W-1:0]   active_ps_q, active_ps_d;
  logic [PRESCALE_W-1:0]   pending_ps_q, pending_ps_d;
  logic                    pending_q, pending_d;
  logic                    load_ack_q, load_ack_d;
  logic                    square_q, square_d;
  logic signed [15:0]      sample_q, sample_d;

  logic                    div_clear;
  logic                    wrap;
  logic                    load_take;
  logic [PRESCALE_W-1:0]   load_val;

  tone_step_divider u_divider (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (div_clear),
    .prescale  (active_ps_q),
    .step_tick (step_tick)
  );

`ifdef TONE_TRIANGLE_EN
  // Rising ramp over the first half period, falling ramp over the second.
  function automatic logic signed [15:0] shape_sample(input logic [PHASE_W-1:0] ph);
    int amp;
    int step;
    int lvl;
    amp  = int'(AMPLITUDE);
    step = amp >>> 6;
    if (!ph[PHASE_W-1]) begin
      lvl = -amp + int'(ph) * step;
    end else begin
      lvl = amp - int'(ph[PHASE_W-2:0]) * step;
    end
    if (lvl > amp)  lvl = amp;
    if (lvl < -amp) lvl = -amp;
    return 16'(lvl);
  endfunction
`else
  function automatic logic signed [15:0] shape_sample(input logic [PHASE_W-1:0] ph);
    return ph[PHASE_W-1] ? AMPLITUDE : -AMPLITUDE;
  endfunction
`endif

  assign div_clear = (state_q == IDLE);
  assign wrap      = step_tick && (phase_q == PHASE_W'(STEPS_PER_PERIOD - 1));
  // A request still high during its own ack cycle is the old one; ignore it.
  assign load_take = load_req && !load_ack_q;
  assign load_val  = clamp_prescale(pre_scale_in, MIN_PRESCALE);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    active_ps_d  = active_ps_q;
    pending_ps_d = pending_ps_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    square_d     = 1'b0;
    sample_d     = '0;

    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)    state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      phase_d = '0;
    end else if (step_tick) begin
      phase_d = phase_q + PHASE_W'(1);
    end

    // Idle: apply at once. Running: park in pending_ps (newest wins) and apply
    // at the wrap; a request landing on the wrap edge itself is applied directly.
    if (state_q == IDLE) begin
      pending_d = 1'b0;
      if (load_take) begin
        active_ps_d = load_val;
        load_ack_d  = 1'b1;
      end
    end else if (wrap) begin
      if (load_take) begin
        active_ps_d = load_val;
        pending_d   = 1'b0;
        load_ack_d  = 1'b1;
      end else if (pending_q) begin
        active_ps_d = pending_ps_q;
        pending_d   = 1'b0;
        load_ack_d  = 1'b1;
      end
    end else if (load_take) begin
      pending_ps_d = load_val;
      pending_d    = 1'b1;
    end

    // Registered from the next phase so outputs line up with phase.
    if (state_d != IDLE) begin
      square_d = phase_d[PHASE_W-1];
      sample_d = shape_sample(phase_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      active_ps_q  <= MIN_PRESCALE;
      pending_ps_q <= MIN_PRESCALE;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      square_q     <= 1'b0;
      sample_q     <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      active_ps_q  <= active_ps_d;
      pending_ps_q <= pending_ps_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      square_q     <= square_d;
      sample_q     <= sample_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign phase      = phase_q;
  assign square_out = square_q;
  assign sample_out = sample_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tone_wave_generator.sv
// -----------------------------------------------------------------------------
// tb_tone_wave_generator
// Directed self-checking bench for tone_wave_generator. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tone_wave_generator;
  import tone_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  enable;
  logic [PRESCALE_W-1:0] pre_scale_in;
  logic                  load_req;
  logic                  load_ack;
  logic                  step_tick;
  logic [7:0]            phase;
  logic                  square_out;
  logic signed [15:0]    sample_out;
  logic                  busy;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int sq_cnt  = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  tone_wave_generator dut (
    .clk          (clk),
    .resetN       (resetN),
    .enable       (enable),
    .pre_scale_in (pre_scale_in),
    .load_req     (load_req),
    .load_ack     (load_ack),
    .step_tick    (step_tick),
    .phase        (phase),
    .square_out   (square_out),
    .sample_out   (sample_out),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int exp_sample(input int p);
`ifdef TONE_TRIANGLE_EN
    if (p < 128) return -8192 + p * 128;
    return 8192 - (p - 128) * 128;
`else
    return (p >= 128) ? 8192 : -8192;
`endif
  endfunction

  // One clock: advance to the next falling edge and update running tallies.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (square_out === 1'b1) sq_cnt++;
    if (load_ack === 1'b1) ack_cnt++;
  endtask

  // Cycles until step_tick is seen (inclusive of the tick cycle).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (step_tick !== 1'b1 && n < 4000);
    if (step_tick !== 1'b1) check("tick_timeout", step_tick, 1);
  endtask

  // Cycles until phase changes to p.
  task automatic wait_phase(input int p, input int budget, output int n);
    logic [7:0] prev;
    n = 0;
    do begin
      prev = phase;
      step();
      n++;
    end while (!(phase == p && prev != p) && n < budget);
    if (phase != p) check("phase_timeout", phase, p);
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (load_ack !== 1'b1 && n < budget);
    if (load_ack !== 1'b1) check("ack_timeout", load_ack, 1);
  endtask

  initial begin
    int n;
    int bad;
    int t_start;
    int t_wrap;
    int t0;

    // Reset and idle
    resetN = 1'b0; enable = 1'b0; load_req = 1'b0; pre_scale_in = '0;
    repeat (3) step();
    check("reset_phase",  phase, 0);
    check("reset_busy",   busy, 0);
    check("reset_square", square_out, 0);
    check("reset_sample", sample_out, 0);
    check("reset_ack",    load_ack, 0);
    check("reset_tick",   step_tick, 0);
    resetN = 1'b1;
    bad = 0;
    repeat (1000) begin
      step();
      if (busy !== 1'b0 || square_out !== 1'b0 || sample_out !== 16'sd0 ||
          step_tick !== 1'b0 || load_ack !== 1'b0 || phase !== 8'd0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Basic tone at 117
    pre_scale_in = 10'h075; load_req = 1'b1;
    step();
    check("idle_ack", load_ack, 1);
    load_req = 1'b0;
    step();
    check("ack_one_cycle", load_ack, 0);
    enable  = 1'b1;
    t_start = cyc + 1;
    sq_cnt  = 0;
    wait_tick(n);
    check("first_tick_latency", n, 117);
    check("run_busy", busy, 1);
    wait_tick(n);
    check("tick_interval_117", n, 117);
    wait_phase(40, 6000, n);
    check("square_phase40", square_out, 0);
    check("sample_phase40", sample_out, exp_sample(40));

    // Mid-tone change to 49 at phase 40
    pre_scale_in = 10'h031; load_req = 1'b1; ack_cnt = 0;
    wait_phase(0, 30000, n);
    check("wrap_period_117", cyc - t_start, 29952);
    check("square_high_117", sq_cnt, 14976);
    check("mid_ack_at_wrap", load_ack, 1);
    check("mid_ack_count", ack_cnt, 1);
    load_req = 1'b0;
    t_wrap   = cyc;
    ack_cnt  = 0;

    // Back-to-back loads during the 49 period
    pre_scale_in = 10'h05D; load_req = 1'b1;
    repeat (2) step();
    pre_scale_in = 10'h03A;
    repeat (3) step();
    wait_phase(0, 13000, n);
    check("wrap_period_49", cyc - t_wrap, 12544);
    check("b2b_ack_at_wrap", load_ack, 1);
    load_req = 1'b0;
    repeat (100) step();
    check("b2b_single_ack", ack_cnt, 1);
    wait_tick(n);
    wait_tick(n);
    check("tick_interval_58", n, 58);

    // Clamp 2 -> 8
    pre_scale_in = 10'h002; load_req = 1'b1;
    wait_ack(16000, n);
    check("clamp_ack_phase", phase, 0);
    load_req = 1'b0;
    wait_tick(n);
    wait_tick(n);
    check("tick_interval_clamped", n, 8);

    // Drain from phase 100
    wait_phase(100, 3000, n);
    enable = 1'b0;
    t0     = cyc;
    sq_cnt = 0;
    step();
    check("drain_busy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check("drain_length", cyc - t0, 1248);
    check("drain_square_high", sq_cnt, 1024);
    check("after_drain_busy", busy, 0);
    check("after_drain_phase", phase, 0);
    check("after_drain_square", square_out, 0);
    check("after_drain_sample", sample_out, 0);

    // Re-enable during DRAIN keeps phase and divider running
    enable = 1'b1;
    wait_phase(50, 1000, n);
    enable = 1'b0;
    step();
    check("drain2_busy", busy, 1);
    enable = 1'b1;
    step();
    check("redrive_phase", phase, 50);
    wait_phase(51, 20, n);
    check("redrive_no_div_reset", n, 6);

    // Reset mid-tone
    wait_phase(200, 3000, n);
    resetN = 1'b0;
    step();
    check("midreset_phase",  phase, 0);
    check("midreset_busy",   busy, 0);
    check("midreset_square", square_out, 0);
    check("midreset_sample", sample_out, 0);
    check("midreset_tick",   step_tick, 0);
    resetN = 1'b1;

    // Waveform at prescale 8 (reset value), enable still high
    step();
    check("wave_phase0_phase", phase, 0);
    check("wave_phase0", sample_out, exp_sample(0));
    wait_phase(64, 1000, n);
    check("wave_phase64", sample_out, exp_sample(64));
    wait_phase(128, 1000, n);
    check("wave_phase128", sample_out, exp_sample(128));
    check("wave_square128", square_out, 1);
    wait_phase(200, 1000, n);
    check("wave_phase200", sample_out, exp_sample(200));
    wait_tick(n);
    wait_tick(n);
    check("tick_interval_reset_ps", n, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
